neopix_frame_ctrl: RTL and testbench
====================================

// Module: neopix_frame_ctrl
// PURPOSE
//  Frame scheduler and pixel source for the WS2812/SK6812 serial driver.
//  Holds a double-buffered pixel RAM: the host side (SPI bridge) fills the back buffer while the front buffer is transmitted.
//  Swaps buffers on commit without tearing, starts driver frames (on commit or periodic auto-refresh) and answers the driver's address/data requests.
// PARAMETERS
//  NUM_LEDS       8        max LEDs in chain; AW = $clog2(NUM_LEDS)
//  FRAME_PERIOD   833333   auto-refresh period in clk_i cycles (60 Hz @ 50 MHz)
//  START_TIMEOUT  16384    cycles to wait for drv_busy_i after a start pulse
// PORTS
//  clk_i               in   1   clock
//  reset_i             in   1   synchronous, active-high reset
//  wr_en_i             in   1   host write strobe into back buffer
//  wr_addr_i           in   AW  host LED index; writes with index >= NUM_LEDS are dropped
//  wr_data_i           in   24  {red,green,blue}
//  commit_i            in   1   pulse: back buffer complete, request swap + frame
//  auto_refresh_i      in   1   1 = retransmit front buffer every FRAME_PERIOD
//  led_count_i         in   AW  LEDs per frame; 0 suppresses all frames
//  brightness_i        in   8   global scale (used only with NEOPIX_BRIGHTNESS_EN)
//  commit_pending_o    out  1   swap requested, not yet taken
//  frame_done_o        out  1   1-cycle pulse when driver drops busy after a frame
//  timeout_o           out  1   sticky until reset: driver never went busy
//  drv_start_o         out  1   start pulse to driver
//  drv_busy_i          in   1   driver busy
//  drv_data_request_i  in   1   driver will sample pixel outputs next cycle (status only)
//  drv_address_i       in   AW  LED index the driver is fetching
//  drv_red_o/drv_green_o/drv_blue_o  out 8 each  pixel for drv_address_i
//  drv_led_count_o     out  AW  frame length, latched per frame
// BEHAVIOUR
//  Reset: all outputs 0, front_sel=0, pending=0, FSM=IDLE, refresh timer=0; RAM contents kept.
//  RAM: 2*NUM_LEDS x 24; write at {~front_sel, wr_addr_i}; read at {front_sel, drv_address_i}.
//  Pixel outputs: registered, fixed latency 2 cycles from drv_address_i/front_sel change (address is stable for >=24 bit periods before sampling).
//  pending: set by commit_i, cleared in SWAP; set wins when both occur in the same cycle.
//  Refresh timer: cleared in START, increments saturating at FRAME_PERIOD-1.
//  FSM:
//   IDLE: led_count_i==0 -> stay. Else pending -> SWAP; else auto_refresh_i && timer==FRAME_PERIOD-1 -> START.
//   SWAP: toggle front_sel, clear pending -> START.
//   START: drv_start_o=1 (exactly one cycle; low in all other states), drv_led_count_o<=led_count_i, clear wait timer -> WAIT_BUSY.
//   WAIT_BUSY: drv_busy_i -> SEND; else wait timer==START_TIMEOUT-1 -> timeout_o<=1, IDLE.
//   SEND: drv_busy_i low -> frame_done_o pulse, IDLE.
//  commit_i during SEND/WAIT_BUSY: only sets pending; swap waits until IDLE (never mid-frame).
//  Writes are accepted in every state and never touch the front buffer.
//  led_count_i changes mid-frame: ignored until next START.
//  Reset mid-frame: FSM to IDLE and drv_start_o low immediately; driver reset separately.
// CONFIGURATION
//  NEOPIX_BRIGHTNESS_EN defined: each channel = (c*brightness_i)>>8 in pipeline stage 2; brightness 255 -> c-(c!=0 ? 1 : 0) not required, exact formula is (c*b)>>8.
//  Undefined: stage 2 is a plain register; brightness_i unused; latency still 2.
// STRUCTURE
//  neopix_pkg: FSM state encodings, pixel field offsets (R 23:16, G 15:8, B 7:0).
//  Sub-module neopix_pixel_ram: simple dual-port synchronous RAM, one write port, one registered read port.
// TESTING
//  1. Write LEDs 0..2 = 0xFF0000,0x00FF00,0x0000FF, led_count=3, commit -> one drv_start_o pulse, front_sel=1, driver outputs those pixels in order, frame_done_o once.
//  2. commit_i while drv_busy_i=1 -> commit_pending_o=1, no start until busy falls, then SWAP+START within 3 cycles.
//  3. auto_refresh_i=1, FRAME_PERIOD=1000, no commits -> starts exactly 1000 cycles apart, front_sel unchanged.
//  4. Stub driver never asserts busy -> timeout_o=1 after START_TIMEOUT cycles, FSM IDLE, stays set until reset_i.
//  5. led_count_i=0 with commit -> no drv_start_o; pending stays 1; set led_count=1 -> frame issued.
//  6. NEOPIX_BRIGHTNESS_EN, brightness=0x80, pixel 0xFF4002 -> outputs 0x7F,0x20,0x01; reset mid-SEND -> all outputs 0 next cycle.

Source files
------------

// File: rtl/neopix_pkg.sv
// Shared definitions for the NeoPixel frame controller: FSM encoding,
// pixel field layout and the brightness scaling helper.
package neopix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SWAP      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_SEND      = 3'd4
  } state_t;

  localparam int PIX_W = 24;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  // (c * b) >> 8, so full brightness trims the top code by one step
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'h00, c} * {8'h00, b};
    return prod[15:8];
  endfunction

endpackage

// File: rtl/neopix_pixel_ram.sv
// Double-buffer pixel store: one write port, one registered read port.
// The buffer select is the MSB of both addresses.
module neopix_pixel_ram
  import neopix_pkg::*;
#(
  parameter int AW = 3,
  parameter int DW = PIX_W
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW:0]   wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW:0]   rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem [0:(2**(AW+1))-1];

  // Host write into whichever buffer the caller addresses
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  // Registered read, first pipeline stage of the pixel path
  always_ff @(posedge clk_i) begin
    rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/neopix_frame_ctrl.sv
// Frame scheduler and pixel source for a WS2812/SK6812 serial driver.
// Host fills the back buffer, commit swaps buffers between frames, frames
// also start from the auto-refresh timer.
// Optional build macro: NEOPIX_BRIGHTNESS_EN scales each channel by
// brightness_i in the second pixel stage; without it that stage is a plain
// register and brightness_i is ignored.
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | no frame in flight, waiting for commit or refresh
// SWAP      | flip front/back buffer, consume the pending commit
// START     | one-cycle start pulse, latch frame length
// WAIT_BUSY | waiting for driver to go busy, bounded by timeout
// SEND      | driver transmitting, waiting for busy to drop
module neopix_frame_ctrl
  import neopix_pkg::*;
#(
  parameter int NUM_LEDS      = 8,
  parameter int FRAME_PERIOD  = 833333,
  parameter int START_TIMEOUT = 16384,
  localparam int AW = $clog2(NUM_LEDS)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [23:0]   wr_data_i,
  input  logic          commit_i,
  input  logic          auto_refresh_i,
  input  logic [AW-1:0] led_count_i,
  input  logic [7:0]    brightness_i,
  output logic          commit_pending_o,
  output logic          frame_done_o,
  output logic          timeout_o,
  output logic          drv_start_o,
  input  logic          drv_busy_i,
  input  logic          drv_data_request_i,
  input  logic [AW-1:0] drv_address_i,
  output logic [7:0]    drv_red_o,
  output logic [7:0]    drv_green_o,
  output logic [7:0]    drv_blue_o,
  output logic [AW-1:0] drv_led_count_o
);

  localparam int RW = $clog2(FRAME_PERIOD);
  localparam int TW = $clog2(START_TIMEOUT);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(FRAME_PERIOD - 1);
  localparam logic [TW-1:0] WAIT_LOAD    = TW'(START_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          front_sel_q;
  logic          pending_q;
  logic [RW-1:0] refresh_tmr_q;
  logic [TW-1:0] wait_tmr_q;
  logic          refresh_due, timeout_hit, frame_end, wr_in_range;
  logic [23:0]   rd_data, pix_d, pix_q;
  logic          unused_data_request;

  assign unused_data_request = drv_data_request_i;

  assign refresh_due = (refresh_tmr_q == REFRESH_LAST);
  assign timeout_hit = (state_q == ST_WAIT_BUSY) && !drv_busy_i && (wait_tmr_q == '0);
  assign frame_end   = (state_q == ST_SEND) && !drv_busy_i;
  assign wr_in_range = ({1'b0, wr_addr_i} < (AW+1)'(NUM_LEDS));

  // Next-state logic; swaps only leave IDLE so a frame never tears
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (led_count_i != '0) begin
          if (pending_q)                         state_d = ST_SWAP;
          else if (auto_refresh_i && refresh_due) state_d = ST_START;
        end
      end
      ST_SWAP:      state_d = ST_START;
      ST_START:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (drv_busy_i)             state_d = ST_SEND;
        else if (wait_tmr_q == '0)  state_d = ST_IDLE;
      end
      ST_SEND:      if (!drv_busy_i) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Buffer select and commit bookkeeping; a new commit beats the clear
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      front_sel_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      if (state_q == ST_SWAP) front_sel_q <= ~front_sel_q;
      if (commit_i)                pending_q <= 1'b1;
      else if (state_q == ST_SWAP) pending_q <= 1'b0;
    end
  end

  // Refresh timer restarts on entry to START so starts land exactly one period apart
  always_ff @(posedge clk_i) begin
    if (reset_i)                   refresh_tmr_q <= '0;
    else if (state_d == ST_START)  refresh_tmr_q <= '0;
    else if (!refresh_due)         refresh_tmr_q <= refresh_tmr_q + 1'b1;
  end

  // Busy-wait down-counter, loaded in START, terminal count at zero
  always_ff @(posedge clk_i) begin
    if (reset_i)                                         wait_tmr_q <= '0;
    else if (state_q == ST_START)                        wait_tmr_q <= WAIT_LOAD;
    else if (state_q == ST_WAIT_BUSY && wait_tmr_q != '0) wait_tmr_q <= wait_tmr_q - 1'b1;
  end

  // Status outputs and per-frame length latch
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      frame_done_o    <= 1'b0;
      timeout_o       <= 1'b0;
      drv_led_count_o <= '0;
    end else begin
      frame_done_o <= frame_end;
      if (timeout_hit)          timeout_o       <= 1'b1;
      if (state_q == ST_START)  drv_led_count_o <= led_count_i;
    end
  end

  assign drv_start_o      = (state_q == ST_START);
  assign commit_pending_o = pending_q;

  neopix_pixel_ram #(.AW(AW), .DW(PIX_W)) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en_i && wr_in_range),
    .wr_addr_i ({~front_sel_q, wr_addr_i}),
    .wr_data_i (wr_data_i),
    .rd_addr_i ({front_sel_q, drv_address_i}),
    .rd_data_o (rd_data)
  );

`ifdef NEOPIX_BRIGHTNESS_EN
  assign pix_d = {scale_chan(rd_data[R_LSB +: 8], brightness_i),
                  scale_chan(rd_data[G_LSB +: 8], brightness_i),
                  scale_chan(rd_data[B_LSB +: 8], brightness_i)};
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness_i;
  assign pix_d = rd_data;
`endif

  // Second pixel stage, cleared on reset so the driver sees black
  always_ff @(posedge clk_i) begin
    if (reset_i) pix_q <= '0;
    else         pix_q <= pix_d;
  end

  assign drv_red_o   = pix_q[R_LSB +: 8];
  assign drv_green_o = pix_q[G_LSB +: 8];
  assign drv_blue_o  = pix_q[B_LSB +: 8];

endmodule

// File: tb/tb_neopix_frame_ctrl.sv
// Self-checking bench for neopix_frame_ctrl with a stub serial driver and a
// two-buffer pixel model.
module tb_neopix_frame_ctrl;

  localparam int NL  = 8;
  localparam int FP  = 1000;
  localparam int STO = 64;

  logic        clk_i = 1'b0;
  logic        reset_i, wr_en_i, commit_i, auto_refresh_i;
  logic [2:0]  wr_addr_i, led_count_i, drv_address_i, drv_led_count_o;
  logic [23:0] wr_data_i;
  logic [7:0]  brightness_i, drv_red_o, drv_green_o, drv_blue_o;
  logic        commit_pending_o, frame_done_o, timeout_o, drv_start_o;
  logic        drv_busy_i, drv_data_request_i;

  always #5 clk_i = ~clk_i;

  neopix_frame_ctrl #(.NUM_LEDS(NL), .FRAME_PERIOD(FP), .START_TIMEOUT(STO)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .commit_i(commit_i), .auto_refresh_i(auto_refresh_i),
    .led_count_i(led_count_i), .brightness_i(brightness_i),
    .commit_pending_o(commit_pending_o), .frame_done_o(frame_done_o),
    .timeout_o(timeout_o), .drv_start_o(drv_start_o), .drv_busy_i(drv_busy_i),
    .drv_data_request_i(drv_data_request_i), .drv_address_i(drv_address_i),
    .drv_red_o(drv_red_o), .drv_green_o(drv_green_o), .drv_blue_o(drv_blue_o),
    .drv_led_count_o(drv_led_count_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int start_cnt = 0;
  int done_cnt  = 0;
  int start_q[$];

  logic [23:0] buf_m [2][NL];
  int          front_m = 0;
  logic [23:0] cap [NL];
  int          cap_n;
  bit          drv_ok;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (drv_start_o) begin
      start_cnt++;
      start_q.push_back(cyc);
    end
    if (frame_done_o) done_cnt++;
  end

  function automatic logic [23:0] exp_px(input logic [23:0] d);
`ifdef NEOPIX_BRIGHTNESS_EN
    int r, g, b;
    r = (int'(d[23:16]) * int'(brightness_i)) / 256;
    g = (int'(d[15:8])  * int'(brightness_i)) / 256;
    b = (int'(d[7:0])   * int'(brightness_i)) / 256;
    return {r[7:0], g[7:0], b[7:0]};
`else
    return d;
`endif
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_px(input int a, input logic [23:0] d);
    wr_en_i = 1'b1; wr_addr_i = 3'(a); wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
    buf_m[1 - front_m][a] = d;
  endtask

  task automatic fill_back();
    for (int a = 0; a < NL; a++) write_px(a, 24'($urandom));
  endtask

  task automatic commit();
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
  endtask

  // Stub driver: waits for a start, goes busy, fetches every LED and drops busy
  task automatic drv_frame(input int dly, input int bound, input int chg);
    int t;
    t = 0; drv_ok = 1'b0; cap_n = 0;
    while (!drv_start_o && t < bound) begin tick(); t++; end
    if (!drv_start_o) return;
    tick();
    if (chg >= 0) led_count_i = 3'(chg);
    repeat (dly) tick();
    drv_busy_i = 1'b1;
    tick();
    cap_n = int'(drv_led_count_o);
    for (int a = 0; a < cap_n; a++) begin
      drv_address_i = 3'(a);
      repeat (3) tick();
      drv_data_request_i = 1'b1;
      tick();
      drv_data_request_i = 1'b0;
      cap[a] = {drv_red_o, drv_green_o, drv_blue_o};
    end
    drv_busy_i = 1'b0;
    tick();
    drv_ok = 1'b1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({commit_pending_o, frame_done_o, timeout_o, drv_start_o, drv_led_count_o,
         drv_red_o, drv_green_o, drv_blue_o} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {commit_pending_o, frame_done_o,
               timeout_o, drv_start_o, drv_led_count_o, drv_red_o, drv_green_o, drv_blue_o});
    end
    reset_i = 1'b0;
    front_m = 0;
    tick();
    n_checks++;
    if ({drv_start_o, commit_pending_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: start/pending %b required 00", {drv_start_o, commit_pending_o});
    end
  endtask

  task automatic test_commit_frame();
    int s0, d0;
    write_px(0, 24'hFF0000);
    write_px(1, 24'h00FF00);
    write_px(2, 24'h0000FF);
    for (int a = 3; a < NL; a++) write_px(a, 24'($urandom));
    led_count_i = 3'd3;
    s0 = start_cnt; d0 = done_cnt;
    commit();
    n_checks++;
    if (commit_pending_o !== 1'b1) begin
      n_fail++; $display("FAIL commit_pending_set: got %b required 1", commit_pending_o);
    end
    front_m = 1;
    drv_frame(2, 10, -1);
    repeat (4) tick();
    n_checks++;
    if (drv_ok !== 1'b1 || cap_n != 3) begin
      n_fail++; $display("FAIL commit_frame_len: ok %b len %0d required 1/3", drv_ok, cap_n);
    end
    for (int a = 0; a < cap_n; a++) begin
      n_checks++;
      if (cap[a] !== exp_px(buf_m[front_m][a])) begin
        n_fail++; $display("FAIL commit_frame_px%0d: got %h required %h", a, cap[a], exp_px(buf_m[front_m][a]));
      end
    end
    n_checks++;
    if (start_cnt - s0 != 1 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL commit_frame_pulses: starts %0d dones %0d required 1/1", start_cnt - s0, done_cnt - d0);
    end
    n_checks++;
    if (commit_pending_o !== 1'b0) begin
      n_fail++; $display("FAIL commit_pending_clear: got %b required 0", commit_pending_o);
    end
  endtask

  task automatic test_commit_during_busy();
    int t, s, k;
    fill_back();
    led_count_i = 3'd5;
    commit();
    front_m ^= 1;
    t = 0;
    while (!drv_start_o && t < 10) begin tick(); t++; end
    tick();
    drv_busy_i = 1'b1;
    tick();
    fill_back();
    commit();
    n_checks++;
    if (commit_pending_o !== 1'b1) begin
      n_fail++; $display("FAIL busy_commit_pending: got %b required 1", commit_pending_o);
    end
    s = start_cnt;
    repeat (10) tick();
    n_checks++;
    if (start_cnt != s) begin
      n_fail++; $display("FAIL busy_no_start: got %0d starts required 0", start_cnt - s);
    end
    drv_busy_i = 1'b0;
    k = 0;
    while (!drv_start_o && k < 8) begin tick(); k++; end
    n_checks++;
    if (!drv_start_o || k > 3) begin
      n_fail++; $display("FAIL busy_swap_latency: start %b after %0d cycles required 1 within 3", drv_start_o, k);
    end
    front_m ^= 1;
    drv_frame(1, 1, -1);
    n_checks++;
    if (drv_ok !== 1'b1 || cap_n != 5) begin
      n_fail++; $display("FAIL busy_frame_len: ok %b len %0d required 1/5", drv_ok, cap_n);
    end
    for (int a = 0; a < cap_n; a++) begin
      n_checks++;
      if (cap[a] !== exp_px(buf_m[front_m][a])) begin
        n_fail++; $display("FAIL busy_frame_px%0d: got %h required %h", a, cap[a], exp_px(buf_m[front_m][a]));
      end
    end
  endtask

  task automatic test_auto_refresh();
    int s, cnt;
    cnt = int'($urandom_range(1, 7));
    led_count_i = 3'(cnt);
    start_q.delete();
    auto_refresh_i = 1'b1;
    for (int f = 0; f < 3; f++) begin
      drv_frame(int'($urandom_range(0, 5)), FP + 100, -1);
      n_checks++;
      if (drv_ok !== 1'b1 || cap_n != cnt) begin
        n_fail++; $display("FAIL auto_frame%0d: ok %b len %0d required 1/%0d", f, drv_ok, cap_n, cnt);
      end
      for (int a = 0; a < cap_n; a++) begin
        n_checks++;
        if (cap[a] !== exp_px(buf_m[front_m][a])) begin
          n_fail++; $display("FAIL auto_px%0d_%0d: got %h required %h", f, a, cap[a], exp_px(buf_m[front_m][a]));
        end
      end
    end
    auto_refresh_i = 1'b0;
    tick();
    n_checks++;
    if (start_q.size() != 3) begin
      n_fail++; $display("FAIL auto_start_count: got %0d required 3", start_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (start_q[i] - start_q[i-1] != FP) begin
          n_fail++; $display("FAIL auto_period%0d: got %0d required %0d", i, start_q[i] - start_q[i-1], FP);
        end
      end
    end
    s = start_cnt;
    repeat (FP + 100) tick();
    n_checks++;
    if (start_cnt != s) begin
      n_fail++; $display("FAIL auto_off_no_start: got %0d starts required 0", start_cnt - s);
    end
  endtask

  task automatic test_zero_count();
    int s, cnt;
    led_count_i = 3'd0;
    fill_back();
    commit();
    s = start_cnt;
    repeat (50) tick();
    n_checks++;
    if (start_cnt != s || commit_pending_o !== 1'b1) begin
      n_fail++; $display("FAIL zero_count_hold: starts %0d pending %b required 0/1", start_cnt - s, commit_pending_o);
    end
    cnt = int'($urandom_range(1, 7));
    led_count_i = 3'(cnt);
    front_m ^= 1;
    drv_frame(3, 10, -1);
    n_checks++;
    if (drv_ok !== 1'b1 || cap_n != cnt || commit_pending_o !== 1'b0) begin
      n_fail++; $display("FAIL zero_count_release: ok %b len %0d pending %b required 1/%0d/0", drv_ok, cap_n, commit_pending_o, cnt);
    end
    for (int a = 0; a < cap_n; a++) begin
      n_checks++;
      if (cap[a] !== exp_px(buf_m[front_m][a])) begin
        n_fail++; $display("FAIL zero_count_px%0d: got %h required %h", a, cap[a], exp_px(buf_m[front_m][a]));
      end
    end
  endtask

  task automatic test_timeout();
    int t, k, d0;
    led_count_i = 3'd2;
    fill_back();
    commit();
    front_m ^= 1;
    d0 = done_cnt;
    t = 0;
    while (!drv_start_o && t < 10) begin tick(); t++; end
    k = 0;
    while (!timeout_o && k < STO + 10) begin tick(); k++; end
    n_checks++;
    if (timeout_o !== 1'b1 || k != STO + 1) begin
      n_fail++; $display("FAIL timeout_delay: timeout %b after %0d cycles required 1 after %0d", timeout_o, k, STO + 1);
    end
    repeat (20) tick();
    n_checks++;
    if (timeout_o !== 1'b1 || done_cnt != d0) begin
      n_fail++; $display("FAIL timeout_sticky: timeout %b dones %0d required 1/0", timeout_o, done_cnt - d0);
    end
    fill_back();
    commit();
    front_m ^= 1;
    drv_frame(1, 4, -1);
    n_checks++;
    if (drv_ok !== 1'b1 || cap_n != 2 || timeout_o !== 1'b1) begin
      n_fail++; $display("FAIL timeout_then_idle: ok %b len %0d timeout %b required 1/2/1", drv_ok, cap_n, timeout_o);
    end
    for (int a = 0; a < cap_n; a++) begin
      n_checks++;
      if (cap[a] !== exp_px(buf_m[front_m][a])) begin
        n_fail++; $display("FAIL timeout_px%0d: got %h required %h", a, cap[a], exp_px(buf_m[front_m][a]));
      end
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    front_m = 0;
    n_checks++;
    if (timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL timeout_reset: got %b required 0", timeout_o);
    end
  endtask

  task automatic test_random_frames();
    int cnt;
    for (int it = 0; it < 6; it++) begin
      fill_back();
      cnt = int'($urandom_range(1, 7));
      led_count_i = 3'(cnt);
      brightness_i = 8'($urandom);
      commit();
      front_m ^= 1;
      drv_frame(int'($urandom_range(0, 8)), 10, int'($urandom_range(0, 7)));
      n_checks++;
      if (drv_ok !== 1'b1 || cap_n != cnt) begin
        n_fail++; $display("FAIL random_len%0d: ok %b len %0d required 1/%0d", it, drv_ok, cap_n, cnt);
      end
      for (int a = 0; a < cap_n; a++) begin
        n_checks++;
        if (cap[a] !== exp_px(buf_m[front_m][a])) begin
          n_fail++; $display("FAIL random_px%0d_%0d: got %h required %h", it, a, cap[a], exp_px(buf_m[front_m][a]));
        end
      end
    end
  endtask

  task automatic test_brightness();
    logic [23:0] want;
`ifdef NEOPIX_BRIGHTNESS_EN
    want = 24'h7F2001;
`else
    want = 24'hFF4002;
`endif
    brightness_i = 8'h80;
    led_count_i = 3'd1;
    write_px(0, 24'hFF4002);
    commit();
    front_m ^= 1;
    drv_frame(0, 10, -1);
    n_checks++;
    if (drv_ok !== 1'b1 || cap[0] !== want) begin
      n_fail++; $display("FAIL brightness_px: ok %b got %h required %h", drv_ok, cap[0], want);
    end
  endtask

  task automatic test_reset_mid_frame();
    int t;
    led_count_i = 3'd4;
    fill_back();
    commit();
    t = 0;
    while (!drv_start_o && t < 10) begin tick(); t++; end
    tick();
    drv_busy_i = 1'b1;
    tick();
    drv_address_i = 3'd1;
    repeat (3) tick();
    reset_i = 1'b1;
    tick();
    n_checks++;
    if ({commit_pending_o, frame_done_o, timeout_o, drv_start_o, drv_led_count_o,
         drv_red_o, drv_green_o, drv_blue_o} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_mid_send: got %h required 0", {commit_pending_o, frame_done_o,
               timeout_o, drv_start_o, drv_led_count_o, drv_red_o, drv_green_o, drv_blue_o});
    end
    reset_i = 1'b0;
    drv_busy_i = 1'b0;
    front_m = 0;
    tick();
    fill_back();
    commit();
    front_m ^= 1;
    drv_frame(2, 10, -1);
    n_checks++;
    if (drv_ok !== 1'b1 || cap_n != 4) begin
      n_fail++; $display("FAIL post_reset_frame: ok %b len %0d required 1/4", drv_ok, cap_n);
    end
    for (int a = 0; a < cap_n; a++) begin
      n_checks++;
      if (cap[a] !== exp_px(buf_m[front_m][a])) begin
        n_fail++; $display("FAIL post_reset_px%0d: got %h required %h", a, cap[a], exp_px(buf_m[front_m][a]));
      end
    end
  endtask

  initial begin
    reset_i = 1'b1; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    commit_i = 1'b0; auto_refresh_i = 1'b0; led_count_i = '0;
    brightness_i = 8'($urandom); drv_busy_i = 1'b0; drv_data_request_i = 1'b0;
    drv_address_i = '0;
    test_reset();
    test_commit_frame();
    test_commit_during_busy();
    test_auto_refresh();
    test_zero_count();
    test_timeout();
    test_random_frames();
    test_brightness();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
